// File: rtl/count_sched_pkg.sv
// rtl/count_sched_pkg.sv - shared FSM state encoding, requester count and grant helper for count_sched
package count_sched_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [NREQ-1:0] onehot_of(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/count_sched_ctr.sv
// rtl/count_sched_ctr.sv - 4-bit loadable wrap-around counter used as the count_sched datapath
module count_sched_ctr (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] in1_i,
  output logic [3:0] cnt_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = load_i ? in1_i : cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_sched.sv
// rtl/count_sched.sv - two-requester job scheduler driving a loadable counter to a terminal count
// COUNT_SCHED_RR_EN selects round-robin tie-breaking; otherwise requester 0 has fixed priority.
module count_sched
  import count_sched_pkg::*;
#(
  parameter logic [3:0] TERM = 4'hF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      start0,
  input  logic [3:0]      start1,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [3:0]      cnt
);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] pick;
  logic            load;
  logic [3:0]      in1;
  logic            win_idx;
  logic            win_req;

  assign win_idx = gnt_q[1];
  assign win_req = req[win_idx];

`ifdef COUNT_SCHED_RR_EN
  logic ptr_q, ptr_d;
  logic job_end;

  always_comb begin
    if (&req) begin
      pick = onehot_of(ptr_q);
    end else begin
      pick = onehot_of(!req[0]);
    end
  end

  // Completed and aborted jobs both hand the pointer to the requester not just served.
  assign job_end = (state_q == DONE) ||
                   (((state_q == LOAD) || (state_q == COUNT)) && !win_req);
  assign ptr_d   = job_end ? ~win_idx : ptr_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick = onehot_of(!req[0]);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    load    = 1'b0;
    in1     = win_idx ? start1 : start0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load = 1'b1;
        if (!win_req) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        // A withdrawn request wins over a coincident terminal count: no done pulse.
        if (!win_req) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (cnt == TERM) begin
          done_d  = gnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  count_sched_ctr u_ctr (
    .clk_i  (CLK),
    .rst_ni (RST),
    .load_i (load),
    .in1_i  (in1),
    .cnt_o  (cnt)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_count_sched.sv
// tb/tb_count_sched.sv - scoreboard bench for count_sched (TERM=F and TERM=3 instances)
module tb_count_sched;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] cnt;
    logic       chk_cnt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] start0 = 4'h0;
  logic [3:0] start1 = 4'h0;
  logic [1:0] gnt_f, done_f, gnt_3, done_3;
  logic       busy_f, busy_3;
  logic [3:0] cnt_f, cnt_3;
  logic       use3 = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  count_sched #(.TERM(4'hF)) dut (
    .CLK(CLK), .RST(RST), .req(req), .start0(start0), .start1(start1),
    .gnt(gnt_f), .done(done_f), .busy(busy_f), .cnt(cnt_f)
  );

  count_sched #(.TERM(4'h3)) dut3 (
    .CLK(CLK), .RST(RST), .req(req), .start0(start0), .start1(start1),
    .gnt(gnt_3), .done(done_3), .busy(busy_3), .cnt(cnt_3)
  );

  wire [1:0] o_gnt  = use3 ? gnt_3  : gnt_f;
  wire [1:0] o_done = use3 ? done_3 : done_f;
  wire       o_busy = use3 ? busy_3 : busy_f;
  wire [3:0] o_cnt  = use3 ? cnt_3  : cnt_f;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_idle();
    sb.push_back('{gnt: 2'b00, done: 2'b00, busy: 1'b0, cnt: 4'h0, chk_cnt: 1'b0});
  endtask

  task automatic push_load(input logic [1:0] g);
    sb.push_back('{gnt: g, done: 2'b00, busy: 1'b1, cnt: 4'h0, chk_cnt: 1'b0});
  endtask

  task automatic push_count(input logic [1:0] g, input logic [3:0] c);
    sb.push_back('{gnt: g, done: 2'b00, busy: 1'b1, cnt: c, chk_cnt: 1'b1});
  endtask

  // Whole job: LOAD, ((term-s) mod 16)+1 COUNT cycles, DONE, then one IDLE cycle.
  task automatic push_job(input logic [1:0] g, input logic [3:0] s, input logic [3:0] term);
    logic [3:0] d;
    logic [3:0] v;
    d = term - s;
    v = s;
    push_load(g);
    for (int k = 0; k <= int'(d); k++) begin
      push_count(g, v);
      v = v + 4'd1;
    end
    sb.push_back('{gnt: g, done: g, busy: 1'b1, cnt: 4'h0, chk_cnt: 1'b0});
    push_idle();
  endtask

  task automatic step(input logic [1:0] req_after);
    exp_t e;
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("gnt", {2'b00, o_gnt}, {2'b00, e.gnt});
    chk("done", {2'b00, o_done}, {2'b00, e.done});
    chk("busy", {3'b000, o_busy}, {3'b000, e.busy});
    if (e.chk_cnt) chk("cnt", o_cnt, e.cnt);
    if (e.done != 2'b00) req = req_after;
  endtask

  task automatic drain(input logic [1:0] req_after);
    while (sb.size() > 0) step(req_after);
  endtask

  task automatic do_reset();
    req = 2'b00;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    sb.delete();
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_gnt", {2'b00, gnt_f}, 4'h0);
    chk("rst_done", {2'b00, done_f}, 4'h0);
    chk("rst_busy", {3'b000, busy_f}, 4'h0);
    chk("rst_cnt", cnt_f, 4'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // Single job, start C, terminal F
    start0 = 4'hC;
    req = 2'b01;
    push_job(2'b01, 4'hC, 4'hF);
    drain(2'b00);
    push_idle();
    step(2'b00);

    // start == TERM: exactly one COUNT cycle
    start0 = 4'hF;
    req = 2'b01;
    push_job(2'b01, 4'hF, 4'hF);
    drain(2'b00);

    // Wrap through zero with TERM = 3
    do_reset();
    use3 = 1'b1;
    start0 = 4'hE;
    req = 2'b01;
    push_job(2'b01, 4'hE, 4'h3);
    drain(2'b00);
    use3 = 1'b0;

    // Tie held from reset
    do_reset();
    start0 = 4'hD;
    start1 = 4'hE;
    req = 2'b11;
`ifdef COUNT_SCHED_RR_EN
    push_job(2'b01, 4'hD, 4'hF);
    push_job(2'b10, 4'hE, 4'hF);
    push_job(2'b01, 4'hD, 4'hF);
    push_job(2'b10, 4'hE, 4'hF);
`else
    for (int j = 0; j < 4; j++) push_job(2'b01, 4'hD, 4'hF);
`endif
    drain(2'b11);

    // Abort r1 at cnt 5, then a tie must go to r0
    do_reset();
    start1 = 4'h2;
    req = 2'b10;
    push_load(2'b10);
    for (int c = 2; c <= 5; c++) push_count(2'b10, 4'(c));
    drain(2'b10);
    req = 2'b00;
    push_idle();
    step(2'b00);
    start0 = 4'hD;
    req = 2'b11;
    push_job(2'b01, 4'hD, 4'hF);
    drain(2'b00);

    // Asynchronous reset in the middle of COUNT
    do_reset();
    start0 = 4'h0;
    req = 2'b01;
    push_load(2'b01);
    for (int c = 0; c < 4; c++) push_count(2'b01, 4'(c));
    drain(2'b01);
    #3;
    RST = 1'b0;
    #1;
    chk("arst_gnt", {2'b00, gnt_f}, 4'h0);
    chk("arst_done", {2'b00, done_f}, 4'h0);
    chk("arst_busy", {3'b000, busy_f}, 4'h0);
    chk("arst_cnt", cnt_f, 4'h0);
    sb.delete();
    req = 2'b00;
    @(negedge CLK);
    RST = 1'b1;
    for (int j = 0; j < 3; j++) push_idle();
    drain(2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter TERM, default 4'hF: terminal count value that ends a job.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 req  input  2  per-requester job request, bit i = requester i; held high until done[i] or abandoned.
REQ-005 start0  input  4  start value for requester 0; sampled only while gnt[0] is high in LOAD.
REQ-006 start1  input  4  start value for requester 1; sampled only while gnt[1] is high in LOAD.
REQ-007 gnt  output  2  one-hot registered grant; all zero when no job is active.
REQ-008 done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 cnt  output  4  current counter value.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, LOAD, COUNT, DONE.
REQ-012 IDLE: when any req bit is high, SHALL select one winner, set gnt one-hot to it, and enter LOAD at the next edge; otherwise SHALL stay in IDLE.
REQ-013 LOAD: SHALL assert counter load for exactly one cycle with in1 = start of the winner, then enter COUNT.
REQ-014 COUNT: load SHALL be low, so the counter increments by 1 per cycle with 4-bit wrap-around (4'hF+1 = 4'h0).
REQ-015 COUNT exit: when cnt == TERM, SHALL enter DONE at the next edge; the counter wrap on that edge is don't-care.
REQ-016 DONE: SHALL pulse done[winner] for one cycle, clear gnt, and return to IDLE.
REQ-017 Latency: a job with start s SHALL take 1 (grant) + 1 (LOAD) + ((TERM - s) mod 16 + 1) (COUNT) + 1 (DONE) cycles.
REQ-018 Start s == TERM SHALL spend exactly one COUNT cycle.
REQ-019 Abort: if req[winner] falls in LOAD or COUNT, SHALL return to IDLE next edge with gnt cleared and no done pulse; the arbitration pointer SHALL still advance.
REQ-020 req changes on a non-granted bit SHALL never affect an active job.
REQ-021 Both req bits high in IDLE: winner per REQ-025/REQ-026; the loser SHALL be served in the next IDLE if still requesting.
REQ-022 A new job SHALL NOT be granted in the DONE cycle; the minimum gap between jobs is one IDLE cycle.

Reset
REQ-023 RST low SHALL, asynchronously and at any state including mid-job, force: state = IDLE, gnt = 0, done = 0, busy = 0, pointer = requester 0, and counter state = 0 (cnt = 0).
REQ-024 After RST deasserts, the first arbitration SHALL occur on the first rising edge with req nonzero.

Configuration
REQ-025 With COUNT_SCHED_RR_EN defined: round-robin arbitration; the pointer SHALL toggle to the other requester after every completed or aborted job, and the requester at the pointer wins ties.
REQ-026 Without COUNT_SCHED_RR_EN: fixed priority, requester 0 SHALL always win ties, and the pointer logic SHALL be absent.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, LOAD, COUNT, DONE) and the requester-count constant NREQ = 2.
REQ-028 The datapath SHALL be one instance of the existing loadable counter module, driven by the FSM's load and in1 and observed through cnt; no other sub-module.

Verification
REQ-029 Single job: req = 01, start0 = 4'hC, TERM = F -> gnt = 01 one cycle later; cnt C, D, E, F; done = 01 pulse; 7 cycles total from request to IDLE.
REQ-030 Tie, RR build: req = 11 held after reset -> order r0, r1, r0, r1; each done pulses once per job.
REQ-031 Tie, fixed-priority build: req = 11 held -> r0 granted every job; done[1] never asserts.
REQ-032 Abort: job for r1 with start1 = 4'h2, drop req[1] when cnt = 4'h5 -> IDLE next edge, gnt = 00, no done; in the RR build r0 wins the next tie.
REQ-033 Wrap/boundary: start0 = 4'hF -> one COUNT cycle, then done; with TERM = 4'h3 and start0 = 4'hE -> cnt E, F, 0, 1, 2, 3, then done.
REQ-034 Async reset: assert RST mid-COUNT between clock edges -> gnt, done, busy, and cnt = 0 immediately; no done pulse after release.
